// File: rtl/sum_window_accumulator_pkg.sv
// Shared types for windowed accumulation stages.
//   win_state_e : IDLE / ACCUM state encoding reused by other windowed stages
//   DEF_*       : default parameter values
package sum_window_accumulator_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } win_state_e;

  localparam int unsigned DEF_SUM_WIDTH   = 6;
  localparam int unsigned DEF_WINDOW_LOG2 = 8;

endpackage

// File: rtl/sum_window_accumulator_if.sv
// Bus between the popcount source/result consumer and the window accumulator.
//   en, sum, sum_valid, acc_ready      : driven by master
//   acc_out, acc_valid, overrun, busy  : driven by slave (accumulator)
interface sum_window_accumulator_if
  import sum_window_accumulator_pkg::*;
#(
  parameter int unsigned SUM_WIDTH   = DEF_SUM_WIDTH,
  parameter int unsigned WINDOW_LOG2 = DEF_WINDOW_LOG2
);
  localparam int unsigned ACC_WIDTH = SUM_WIDTH + WINDOW_LOG2;

  logic                 en;
  logic [SUM_WIDTH-1:0] sum;
  logic                 sum_valid;
  logic [ACC_WIDTH-1:0] acc_out;
  logic                 acc_valid;
  logic                 acc_ready;
  logic                 overrun;
  logic                 busy;

  modport master (
    output en, sum, sum_valid, acc_ready,
    input  acc_out, acc_valid, overrun, busy
  );

  modport slave (
    input  en, sum, sum_valid, acc_ready,
    output acc_out, acc_valid, overrun, busy
  );
endinterface

// File: rtl/sum_window_accumulator_window_counter.sv
// Sample counter for one window.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : synchronous clear (priority over inc)
//   inc        : count one sample
//   tc_c       : counter is at its terminal value (combinational)
module window_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic tc_c
);
  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= cnt + WIDTH'(1);
  end

  assign tc_c = &cnt;
endmodule

// File: rtl/sum_window_accumulator.sv
// Sums 2**WINDOW_LOG2 valid popcount samples per window, back to back while
// en is high, and presents each total on a valid/ready output with a sticky
// overrun flag for results overwritten before being consumed.
//   CLK, nRST : clock, synchronous active-low reset
//   bus       : slave side of sum_window_accumulator_if
module sum_window_accumulator
  import sum_window_accumulator_pkg::*;
#(
  parameter int unsigned SUM_WIDTH   = DEF_SUM_WIDTH,
  parameter int unsigned WINDOW_LOG2 = DEF_WINDOW_LOG2
) (
  input  logic CLK,
  input  logic nRST,
  sum_window_accumulator_if.slave bus
);
  localparam int unsigned ACC_WIDTH = SUM_WIDTH + WINDOW_LOG2;

  win_state_e           state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_WIDTH-1:0] acc_out_q, acc_out_d;
  logic                 acc_valid_q, acc_valid_d;
  logic                 overrun_q, overrun_d;
  logic                 busy_q, busy_d;
  logic                 cnt_clr, cnt_inc, cnt_tc_c;
  logic [ACC_WIDTH-1:0] acc_sum_c;

  window_counter #(.WIDTH(WINDOW_LOG2)) u_window_counter (
    .clk   (CLK),
    .rst_n (nRST),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .tc_c  (cnt_tc_c)
  );

  assign acc_sum_c = acc_q + ACC_WIDTH'(bus.sum);

  // State register and all registered outputs
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      acc_out_q   <= '0;
      acc_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      acc_out_q   <= acc_out_d;
      acc_valid_q <= acc_valid_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state, accumulation and result handshake
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    acc_out_d   = acc_out_q;
    acc_valid_d = acc_valid_q;
    overrun_d   = overrun_q;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;

    // Consume; a load below overrides this so coincident consume/load keeps valid
    if (acc_valid_q && bus.acc_ready) acc_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        acc_d   = '0;
        cnt_clr = 1'b1;
        if (bus.en) begin
          state_d   = ACCUM;
          overrun_d = 1'b0;
        end
      end
      ACCUM: begin
        if (!bus.en) begin
          // Abort wins over a final sample: partial window is dropped
          state_d = IDLE;
          acc_d   = '0;
          cnt_clr = 1'b1;
        end else if (bus.sum_valid) begin
          if (cnt_tc_c) begin
            acc_out_d   = acc_sum_c;
            acc_valid_d = 1'b1;
            if (acc_valid_q && !bus.acc_ready) overrun_d = 1'b1;
            acc_d   = '0;
            cnt_clr = 1'b1;
          end else begin
            acc_d   = acc_sum_c;
            cnt_inc = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == ACCUM);
  end

  assign bus.acc_out   = acc_out_q;
  assign bus.acc_valid = acc_valid_q;
  assign bus.overrun   = overrun_q;
  assign bus.busy      = busy_q;
endmodule
